// File: rtl/oser_pkg.sv
// Shared types and constants for the oser_tx fabric serializer.
package oser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAIN,
        ST_RUN
    } state_e;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 16;

    localparam logic [15:0] DEF_IDLE_PAT  = 16'h0000;
    localparam logic [15:0] DEF_TRAIN_PAT = 16'h001F;

    function automatic bit width_ok(input int unsigned w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/oser_slot_timer.sv
// Bit-slot counter: boundary strobe (load_o) and divided word clock (pclk_o).
module oser_slot_timer
    import oser_pkg::*;
#(
    parameter int unsigned WIDTH = 10
) (
    input  logic clk_i,
    input  logic nrst_i,
    output logic load_o,
    output logic pclk_o
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] HALF = CW'((WIDTH + 1) / 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pclk_q, pclk_d;

    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        // high for the first half of the word, so it rises with bit 0
        pclk_d = (cnt_d < HALF);
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            cnt_q  <= LAST;
            pclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pclk_q <= pclk_d;
        end
    end

    assign load_o = (cnt_q == LAST);
    assign pclk_o = pclk_q;

endmodule

// File: rtl/oser_tx.sv
// N:1 LSB-first serializer with one-word holding buffer, training and idle fill.
module oser_tx
    import oser_pkg::*;
#(
    parameter int unsigned       WIDTH     = 10,
    parameter logic [WIDTH-1:0]  IDLE_PAT  = WIDTH'(DEF_IDLE_PAT),
    parameter logic [WIDTH-1:0]  TRAIN_PAT = WIDTH'(DEF_TRAIN_PAT)
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             train_i,
    input  logic             clr_underrun_i,
    output logic             q_o,
    output logic             pclk_o,
    output logic             load_o,
    output logic             underrun_o
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("oser_tx: WIDTH out of range");
    end

    logic             load_c;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic             ready_q, ready_d;
    logic             underrun_q, underrun_d;

    logic             accept_c;
    logic             drain_c;
    logic             set_ur_c;

    oser_slot_timer #(
        .WIDTH (WIDTH)
    ) u_slot_timer (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .load_o (load_c),
        .pclk_o (pclk_o)
    );

    // Next-state, shift-register load selection, buffer and flag update
    always_comb begin
        state_d    = state_q;
        shreg_d    = {1'b0, shreg_q[WIDTH-1:1]};
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        drain_c    = 1'b0;
        set_ur_c   = 1'b0;
        accept_c   = valid_i && !buf_full_q;

        if (accept_c) begin
            buf_d      = data_i;
            buf_full_d = 1'b1;
        end

        if (load_c) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (train_i) begin
                        state_d = ST_TRAIN;
                    end else if (buf_full_q) begin
                        state_d = ST_RUN;
                        drain_c = 1'b1;
                    end
                end
                ST_TRAIN: begin
                    if (!train_i) begin
                        if (buf_full_q) begin
                            state_d = ST_RUN;
                            drain_c = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_RUN: begin
                    if (train_i) begin
                        state_d = ST_TRAIN;
                    end else if (buf_full_q) begin
                        drain_c = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        set_ur_c = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // reload is chosen by the state we are entering
            if (drain_c) begin
                shreg_d    = buf_q;
                buf_full_d = 1'b0;
            end else if (state_d == ST_TRAIN) begin
                shreg_d = TRAIN_PAT;
            end else begin
                shreg_d = IDLE_PAT;
            end
        end

        ready_d = !buf_full_d;

        // set has priority over a coincident clear
        if (set_ur_c) begin
            underrun_d = 1'b1;
        end else if (clr_underrun_i) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q    <= ST_IDLE;
            shreg_q    <= IDLE_PAT;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            ready_q    <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
        end
    end

    assign q_o        = shreg_q[0];
    assign ready_o    = ready_q;
    assign load_o     = load_c;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_oser_tx.sv
// Scoreboard bench for oser_tx: expected words queued by stimulus, checked per received frame.
module tb_oser_tx;

    localparam int unsigned W = 10;

    logic         clk_i = 1'b0;
    logic         nrst_i;
    logic [W-1:0] data_i;
    logic         valid_i;
    logic         ready_o;
    logic         train_i;
    logic         clr_underrun_i;
    logic         q_o;
    logic         pclk_o;
    logic         load_o;
    logic         underrun_o;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] sb[$];

    logic rlow_en = 1'b0;
    int   rlow    = 0;

    oser_tx #(
        .WIDTH     (W),
        .IDLE_PAT  (10'h000),
        .TRAIN_PAT (10'h01F)
    ) dut (
        .clk_i          (clk_i),
        .nrst_i         (nrst_i),
        .data_i         (data_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .train_i        (train_i),
        .clr_underrun_i (clr_underrun_i),
        .q_o            (q_o),
        .pclk_o         (pclk_o),
        .load_o         (load_o),
        .underrun_o     (underrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame monitor: a frame starts at a pclk rise and ends W negedges later
    initial begin : monitor
        int           bidx;
        logic         prev_pclk;
        logic [W-1:0] got;
        logic [W-1:0] pc;
        logic [W-1:0] exp_w;
        bidx      = -1;
        prev_pclk = 1'b0;
        got       = '0;
        pc        = '0;
        forever begin
            @(negedge clk_i);
            if (!nrst_i) begin
                bidx      = -1;
                prev_pclk = 1'b0;
            end else begin
                if (pclk_o && !prev_pclk) bidx = 0;
                else if (bidx >= 0)       bidx++;
                if (bidx >= 0 && bidx < int'(W)) begin
                    got[bidx] = q_o;
                    pc[bidx]  = pclk_o;
                end
                if (bidx == int'(W) - 1) begin
                    if (sb.size() > 0) begin
                        exp_w = sb.pop_front();
                        chk("word", 32'(got), 32'(exp_w));
                        chk("pclk_shape", 32'(pc), 32'h01F);
                    end
                    bidx = -1;
                end
                prev_pclk = pclk_o;
            end
        end
    end

    initial begin : ready_low_counter
        forever begin
            @(negedge clk_i);
            if (rlow_en && !ready_o) rlow++;
        end
    end

    task automatic wait_boundary();
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!load_o && n < 50);
        if (!load_o) chk("boundary_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'(0));
            sb.delete();
        end
    endtask

    // Hold valid with w until the DUT accepts it; returns on the negedge after the accept edge
    task automatic send(input logic [W-1:0] w);
        logic r;
        logic acc;
        int   n;
        data_i  = w;
        valid_i = 1'b1;
        acc     = 1'b0;
        n       = 0;
        while (!acc && n < 100) begin
            r = ready_o;
            @(negedge clk_i);
            acc = r;
            n++;
        end
        if (!acc) chk("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic pulse_clr();
        clr_underrun_i = 1'b1;
        @(negedge clk_i);
        clr_underrun_i = 1'b0;
    endtask

    initial begin : stim
        nrst_i         = 1'b0;
        data_i         = '0;
        valid_i        = 1'b0;
        train_i        = 1'b0;
        clr_underrun_i = 1'b0;

        // 1: reset values, then idle frames with 5/5 word clock
        repeat (3) @(negedge clk_i);
        chk("rst_q", 32'(q_o), 32'(0));
        chk("rst_pclk", 32'(pclk_o), 32'(0));
        chk("rst_ready", 32'(ready_o), 32'(1));
        chk("rst_underrun", 32'(underrun_o), 32'(0));
        chk("rst_load", 32'(load_o), 32'(1));
        nrst_i = 1'b1;
        wait_boundary();
        #1;
        sb.push_back(10'h000);
        sb.push_back(10'h000);
        wait_drain();

        // 2: single word, then underrun idle
        wait_boundary();
        #1;
        sb.push_back(10'h000);
        sb.push_back(10'h2A5);
        sb.push_back(10'h000);
        send(10'h2A5);
        valid_i = 1'b0;
        chk("t2_ready_full", 32'(ready_o), 32'(0));
        wait_drain();
        chk("t2_underrun", 32'(underrun_o), 32'(1));

        // 3: back-to-back stream
        pulse_clr();
        chk("t3_clr", 32'(underrun_o), 32'(0));
        wait_boundary();
        #1;
        sb.push_back(10'h000);
        sb.push_back(10'h3FF);
        sb.push_back(10'h000);
        sb.push_back(10'h155);
        sb.push_back(10'h000);
        rlow    = 0;
        rlow_en = 1'b1;
        send(10'h3FF);
        send(10'h000);
        send(10'h155);
        valid_i = 1'b0;
        while (sb.size() > 1) begin
            @(negedge clk_i);
            #1;
        end
        chk("t3_no_underrun", 32'(underrun_o), 32'(0));
        wait_drain();
        rlow_en = 1'b0;
        chk("t3_ready_low_cycles", 32'(rlow), 32'(28));
        chk("t3_underrun_end", 32'(underrun_o), 32'(1));

        // 4: sticky underrun, clear, coincident set+clear
        wait_boundary();
        @(negedge clk_i);
        chk("t4_sticky", 32'(underrun_o), 32'(1));
        pulse_clr();
        chk("t4_cleared", 32'(underrun_o), 32'(0));
        wait_boundary();
        #1;
        sb.push_back(10'h000);
        sb.push_back(10'h0F0);
        sb.push_back(10'h000);
        send(10'h0F0);
        valid_i = 1'b0;
        wait_boundary();
        wait_boundary();
        chk("t4_pre_set", 32'(underrun_o), 32'(0));
        pulse_clr();
        chk("t4_set_wins", 32'(underrun_o), 32'(1));
        wait_drain();

        // 5: training holds the buffered word
        pulse_clr();
        wait_boundary();
        #1;
        sb.push_back(10'h01F);
        sb.push_back(10'h01F);
        sb.push_back(10'h2A5);
        sb.push_back(10'h000);
        train_i = 1'b1;
        send(10'h2A5);
        valid_i = 1'b0;
        chk("t5_ready_train", 32'(ready_o), 32'(0));
        wait_boundary();
        @(negedge clk_i);
        chk("t5_buffer_held", 32'(ready_o), 32'(0));
        train_i = 1'b0;
        wait_drain();
        chk("t5_underrun", 32'(underrun_o), 32'(1));

        // 6: reset mid-word with a word buffered
        wait_boundary();
        #1;
        sb.push_back(10'h000);
        send(10'h3FF);
        send(10'h155);
        valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("t6_pre_q", 32'(q_o), 32'(1));
        chk("t6_pre_ready", 32'(ready_o), 32'(0));
        chk("t6_pre_sb_empty", 32'(sb.size()), 32'(0));
        nrst_i = 1'b0;
        #1;
        chk("t6_rst_q", 32'(q_o), 32'(0));
        chk("t6_rst_ready", 32'(ready_o), 32'(1));
        chk("t6_rst_pclk", 32'(pclk_o), 32'(0));
        chk("t6_rst_underrun", 32'(underrun_o), 32'(0));
        repeat (2) @(negedge clk_i);
        nrst_i = 1'b1;
        wait_boundary();
        #1;
        sb.push_back(10'h000);
        sb.push_back(10'h000);
        sb.push_back(10'h000);
        wait_drain();
        chk("t6_no_underrun", 32'(underrun_o), 32'(0));
        chk("t6_ready_end", 32'(ready_o), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
